// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the SRAM readback engine.
package sram_rd_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_RD_LATENCY    = 2;

    // Legal range of the SRAM read latency; the latency counter is sized for the maximum.
    localparam int RD_LATENCY_MIN  = 1;
    localparam int RD_LATENCY_MAX  = 7;
    localparam int LAT_COUNT_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        PUSH = 3'd3,
        DONE = 3'd4
    } rd_state_t;

endpackage

// File: rtl/sram_rd_lat_counter.sv
// Counts the cycles spent waiting for SRAM read data and flags the capture cycle.
module sram_rd_lat_counter
    import sram_rd_pkg::*;
#(
    parameter int RD_LATENCY = DEFAULT_RD_LATENCY
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [LAT_COUNT_WIDTH-1:0] TERMINAL_COUNT = LAT_COUNT_WIDTH'(RD_LATENCY - 1);

    logic [LAT_COUNT_WIDTH-1:0] count;

    // Count up while enabled and park on the terminal value until the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERMINAL_COUNT);

endmodule

// File: rtl/sram_readback_ctrl.sv
// Boot image readback engine: streams a block of SRAM words into a downstream FIFO,
// sharing the SRAM port with the microprocessor via micro_control.
module sram_readback_ctrl
    import sram_rd_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int RD_LATENCY    = DEFAULT_RD_LATENCY
)(
    input  logic                     rdctl_mem_clk_i,
    input  logic                     rdctl_mem_rst_n_i,
    input  logic                     start_i,
    input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
    input  logic [ADDRESS_WIDTH:0]   word_count_i,
    input  logic                     micro_control,
    input  logic [ADDRESS_WIDTH-1:0] micro_sram_address_i,
    input  logic                     micro_sram_cs_i,
    input  logic                     micro_sram_we_i,
    input  logic [DATA_WIDTH-1:0]    sram_dataout_i,
    output logic [ADDRESS_WIDTH-1:0] sram_address_o,
    output logic                     sram_cs_o,
    output logic                     sram_we_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_write_o,
    output logic [DATA_WIDTH-1:0]    fifo_dataout_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     abort_o
);

    localparam logic [ADDRESS_WIDTH:0] LAST_WORD = (ADDRESS_WIDTH+1)'(1);

    rd_state_t                state;
    rd_state_t                state_next;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0]    hold_data;
    logic                     abort_flag;

    logic launch;
    logic push;
    logic capture;
    logic kill;
    logic int_cs;
    logic lat_clear;
    logic lat_enable;
    logic lat_terminal;

    sram_rd_lat_counter #(
        .RD_LATENCY (RD_LATENCY)
    ) u_lat_counter (
        .clk      (rdctl_mem_clk_i),
        .rst_n    (rdctl_mem_rst_n_i),
        .clear    (lat_clear),
        .enable   (lat_enable),
        .terminal (lat_terminal)
    );

    // State register.
    always_ff @(posedge rdctl_mem_clk_i or negedge rdctl_mem_rst_n_i) begin
        if (!rdctl_mem_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; the micro grabbing the port kills any transfer at once.
    always_comb begin
        state_next   = state;
        launch       = 1'b0;
        push         = 1'b0;
        capture      = 1'b0;
        kill         = 1'b0;
        int_cs       = 1'b1;
        lat_clear    = 1'b0;
        lat_enable   = 1'b0;
        fifo_write_o = 1'b0;
        done_o       = 1'b0;

        if (state != IDLE && micro_control) begin
            kill       = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !micro_control) begin
                        launch     = 1'b1;
                        state_next = (word_count_i == '0) ? DONE : ADDR;
                    end
                end
                ADDR: begin
                    int_cs     = 1'b0;
                    lat_clear  = 1'b1;
                    state_next = WAIT;
                end
                WAIT: begin
                    int_cs     = 1'b0;
                    lat_enable = 1'b1;
                    if (lat_terminal) begin
                        capture    = 1'b1;
                        state_next = PUSH;
                    end
                end
                PUSH: begin
                    if (!fifo_full_i) begin
                        push         = 1'b1;
                        fifo_write_o = 1'b1;
                        state_next   = (remaining == LAST_WORD) ? DONE : ADDR;
                    end
                end
                DONE: begin
                    done_o     = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Address/remaining counters, read-data holding register and the abort pulse.
    always_ff @(posedge rdctl_mem_clk_i or negedge rdctl_mem_rst_n_i) begin
        if (!rdctl_mem_rst_n_i) begin
            addr       <= '0;
            remaining  <= '0;
            hold_data  <= '0;
            abort_flag <= 1'b0;
        end else begin
            abort_flag <= kill;
            if (launch) begin
                addr      <= base_addr_i;
                remaining <= word_count_i;
            end else if (push) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (capture) begin
                hold_data <= sram_dataout_i;
            end
        end
    end

    assign busy_o         = (state != IDLE);
    assign abort_o        = abort_flag;
    assign fifo_dataout_o = hold_data;

    assign sram_address_o = micro_control ? micro_sram_address_i : addr;
    assign sram_cs_o      = micro_control ? micro_sram_cs_i      : int_cs;
    assign sram_we_o      = micro_control ? micro_sram_we_i      : 1'b1;

endmodule
